// File: rtl/icache_pkg.sv
// icache_pkg: shared types and default geometry for the instruction cache.
//   icache_state_e : controller states (IDLE, LOOKUP, FILL)
//   OFF_W/IDX_W/TAG_W : address field widths for the default geometry
//   split_addr()   : splits a byte address into tag / index / word offset
package icache_pkg;

    localparam int unsigned LINES_DEF      = 64;
    localparam int unsigned LINE_WORDS_DEF = 4;

    localparam int unsigned OFF_W = $clog2(LINE_WORDS_DEF);
    localparam int unsigned IDX_W = $clog2(LINES_DEF);
    localparam int unsigned TAG_W = 32 - IDX_W - OFF_W - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2
    } icache_state_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] off;
    } addr_split_t;

    // Byte-address split for the default geometry; bits [1:0] are dropped.
    function automatic addr_split_t split_addr(input logic [31:0] a);
        addr_split_t s;
        s.tag = a[31 -: TAG_W];
        s.idx = a[OFF_W+2 +: IDX_W];
        s.off = a[2 +: OFF_W];
        return s;
    endfunction

endpackage

// File: rtl/icache_ram.sv
// icache_ram: tag + data storage for the instruction cache.
// One write port, one synchronous read port (registered outputs), no reset,
// so it maps onto block RAM. A read at the written index in the same cycle
// returns the previous contents.
//   i_clk     : clock
//   i_we      : write enable
//   i_wr_idx  : write line index
//   i_wr_tag  : tag to store
//   i_wr_line : full line to store (word 0 in the low bits)
//   i_rd_idx  : read line index, sampled on posedge
//   o_rd_tag  : tag read on the previous edge
//   o_rd_line : line read on the previous edge
module icache_ram #(
    parameter int unsigned LINES     = 64,
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned TAG_W     = 22,
    parameter int unsigned LINE_BITS = 128
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [IDX_W-1:0]     i_wr_idx,
    input  logic [TAG_W-1:0]     i_wr_tag,
    input  logic [LINE_BITS-1:0] i_wr_line,
    input  logic [IDX_W-1:0]     i_rd_idx,
    output logic [TAG_W-1:0]     o_rd_tag,
    output logic [LINE_BITS-1:0] o_rd_line
);

    logic [TAG_W-1:0]     r_tag_mem  [LINES];
    logic [LINE_BITS-1:0] r_data_mem [LINES];
    logic [TAG_W-1:0]     r_rd_tag;
    logic [LINE_BITS-1:0] r_rd_line;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_tag_mem[i_wr_idx]  <= i_wr_tag;
            r_data_mem[i_wr_idx] <= i_wr_line;
        end
        r_rd_tag  <= r_tag_mem[i_rd_idx];
        r_rd_line <= r_data_mem[i_rd_idx];
    end

    assign o_rd_tag  = r_rd_tag;
    assign o_rd_line = r_rd_line;

endmodule

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache between the IF stage
// and a req/ack word bus. Misses refill a whole line in order, word 0 first.
//   clk, rst_n  : clock, synchronous active-low reset
//   instr_addr  : fetch address for the next cycle (IF nextpc)
//   instr_data  : word for the registered request address, valid when !instr_busy
//   instr_busy  : 1 = instr_data not valid this cycle
//   flush       : invalidate all lines
//   mem_req     : word read request, held until mem_ack
//   mem_addr    : word-aligned read address, stable while mem_req
//   mem_ack     : one-cycle completion, mem_rdata valid in the same cycle
//   mem_rdata   : read data
module icache
    import icache_pkg::*;
#(
    parameter int unsigned LINES      = LINES_DEF,
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data,
    output logic        instr_busy,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned C_OFF_W     = $clog2(LINE_WORDS);
    localparam int unsigned C_IDX_W     = $clog2(LINES);
    localparam int unsigned C_TAG_LSB   = C_OFF_W + C_IDX_W + 2;
    localparam int unsigned C_TAG_W     = 32 - C_TAG_LSB;
    localparam int unsigned C_LINE_BITS = LINE_WORDS * 32;
    localparam logic [C_OFF_W-1:0] C_LAST = C_OFF_W'(LINE_WORDS - 1);

    icache_state_e r_state, w_state_nxt;

    logic [31:0]          r_req_addr;
    logic [31:0]          r_pend_addr;
    logic [LINES-1:0]     r_valid;
    logic                 r_mem_req;
    logic [31:0]          r_mem_addr;
    logic [C_OFF_W-1:0]   r_cnt;
    logic [31:0]          r_linebuf [LINE_WORDS];
    logic                 r_fwd;
    logic                 r_stale;

    logic                 w_accept;
    logic                 w_start_fill;
    logic                 w_last_ack;
    logic                 w_busy;
    logic                 w_hit;
    logic                 w_pend_in_line;
    logic [C_OFF_W-1:0]   w_req_off;
    logic [C_IDX_W-1:0]   w_req_idx;
    logic [C_TAG_W-1:0]   w_req_tag;
    logic [C_IDX_W-1:0]   w_pend_idx;
    logic [C_IDX_W-1:0]   w_in_idx;
    logic [C_IDX_W-1:0]   w_rd_idx;
    logic [C_TAG_W-1:0]   w_rd_tag;
    logic [C_LINE_BITS-1:0] w_rd_line;
    logic [C_LINE_BITS-1:0] w_wr_line;
    logic [31:0]          w_arr_word;
    logic [31:0]          w_buf_word;
    logic                 w_unused;

    assign w_req_off  = r_req_addr[2 +: C_OFF_W];
    assign w_req_idx  = r_req_addr[C_OFF_W+2 +: C_IDX_W];
    assign w_req_tag  = r_req_addr[31:C_TAG_LSB];
    assign w_pend_idx = r_pend_addr[C_OFF_W+2 +: C_IDX_W];
    assign w_in_idx   = instr_addr[C_OFF_W+2 +: C_IDX_W];
    assign w_pend_in_line = (r_pend_addr[31:C_OFF_W+2] == r_req_addr[31:C_OFF_W+2]);
    assign w_unused   = ^r_req_addr[1:0];

    // r_stale: the line at this index was replaced on the previous edge,
    // so the RAM returned its old contents; treat that lookup as a miss.
    assign w_hit = r_valid[w_req_idx] && (w_rd_tag == w_req_tag) && !r_stale;

    // Next-state and strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_start_fill = 1'b0;
        w_last_ack   = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                w_accept    = 1'b1;
                w_state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (r_fwd || w_hit) begin
                    w_busy   = 1'b0;
                    w_accept = 1'b1;
                end else begin
                    w_start_fill = 1'b1;
                    w_state_nxt  = FILL;
                end
            end
            FILL: begin
                if (mem_ack && (r_cnt == C_LAST)) begin
                    w_last_ack  = 1'b1;
                    w_state_nxt = LOOKUP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Word selection from RAM output and from the fill buffer
    always_comb begin
        w_arr_word = '0;
        w_buf_word = '0;
        for (int unsigned k = 0; k < LINE_WORDS; k++) begin
            if (w_req_off == C_OFF_W'(k)) begin
                w_arr_word = w_rd_line[k*32 +: 32];
                w_buf_word = r_linebuf[k];
            end
        end
    end

    // The last word goes straight from the bus into the array write.
    always_comb begin
        w_wr_line = '0;
        for (int unsigned k = 0; k < LINE_WORDS; k++) begin
            w_wr_line[k*32 +: 32] = (k == LINE_WORDS - 1) ? mem_rdata : r_linebuf[k];
        end
    end

    assign w_rd_idx   = w_last_ack ? w_pend_idx : w_in_idx;
    assign instr_busy = w_busy;
    assign instr_data = w_busy ? '0 : (r_fwd ? w_buf_word : w_arr_word);
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_req_addr  <= '0;
            r_pend_addr <= '0;
            r_cnt       <= '0;
            r_fwd       <= 1'b0;
            r_stale     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_req_addr <= instr_addr;
                r_fwd      <= 1'b0;
                r_stale    <= 1'b0;
            end
            if (w_start_fill) begin
                r_mem_req   <= 1'b1;
                r_mem_addr  <= {r_req_addr[31:C_OFF_W+2], {(C_OFF_W+2){1'b0}}};
                r_pend_addr <= instr_addr;
                r_cnt       <= '0;
            end
            if (r_state == FILL) begin
                r_pend_addr <= instr_addr;
                if (mem_ack) begin
                    r_mem_addr <= r_mem_addr + 32'd4;
                    r_cnt      <= r_cnt + C_OFF_W'(1);
                end
            end
            if (w_last_ack) begin
                r_mem_req  <= 1'b0;
                r_req_addr <= r_pend_addr;
                r_fwd      <= w_pend_in_line;
                r_stale    <= !w_pend_in_line && (w_pend_idx == w_req_idx);
            end
            if (flush) begin
                r_valid <= '0;
            end else if (w_last_ack) begin
                r_valid[w_req_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == FILL && mem_ack) begin
            r_linebuf[r_cnt] <= mem_rdata;
        end
    end

    icache_ram #(
        .LINES     (LINES),
        .IDX_W     (C_IDX_W),
        .TAG_W     (C_TAG_W),
        .LINE_BITS (C_LINE_BITS)
    ) u_ram (
        .i_clk     (clk),
        .i_we      (w_last_ack),
        .i_wr_idx  (w_req_idx),
        .i_wr_tag  (w_req_tag),
        .i_wr_line (w_wr_line),
        .i_rd_idx  (w_rd_idx),
        .o_rd_tag  (w_rd_tag),
        .o_rd_line (w_rd_line)
    );

endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache. An IF-stage model presents
// nextpc (current pc while busy), pushes the expected word whenever it
// presents a new pc and pops/compares it when instr_busy drops. A memory
// model answers mem_req with a configurable delay and checks the fill
// address order against a second queue.
module tb_icache;
    import icache_pkg::*;

    localparam int unsigned LW = LINE_WORDS_DEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_addr = '0;
    logic [31:0] instr_data;
    logic        instr_busy;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    icache #(
        .LINES      (64),
        .LINE_WORDS (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .instr_busy (instr_busy),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int unsigned n_acks = 0;
    int unsigned ack_delay = 0;
    bit          flush_on_last = 1'b0;

    logic [31:0] exp_q  [$];
    logic [31:0] fill_q [$];
    logic [31:0] pc_q   [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_fill(input logic [31:0] a);
        addr_split_t s;
        logic [31:0] base;
        s    = split_addr(a);
        base = {s.tag, s.idx, {(OFF_W+2){1'b0}}};
        for (int i = 0; i < LW; i++) fill_q.push_back(base + 32'(4 * i));
    endtask

    // Memory responder
    initial begin : mem_model
        int unsigned wait_cnt;
        int unsigned word_k;
        logic [31:0] held;
        wait_cnt = 0;
        word_k   = 0;
        held     = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            flush   = 1'b0;
            if (rst_n && mem_req) begin
                if (wait_cnt > 0) check("req_hold", mem_addr, held);
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    n_acks++;
                    if (fill_q.size() != 0) check("fill_addr", mem_addr, fill_q.pop_front());
                    else check("fill_unexpected", n_acks, 0);
                    if (flush_on_last && word_k == LW - 1) flush = 1'b1;
                    word_k   = (word_k == LW - 1) ? 0 : word_k + 1;
                    wait_cnt = 0;
                end else begin
                    held = mem_addr;
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                word_k   = 0;
            end
        end
    end

    // IF-stage model: runs the addresses in pc_q, optional redirect.
    task automatic run(input int unsigned budget, input int unsigned redir_at,
                       input logic [31:0] redir_addr, output int unsigned cycles);
        logic [31:0] pc;
        bit done;
        done   = 1'b0;
        cycles = 0;
        pc = pc_q.pop_front();
        exp_q.push_back(mem_word(pc));
        instr_addr = pc;
        while (!done) begin
            @(posedge clk);
            #1;
            cycles++;
            if (redir_at != 0 && cycles == redir_at) begin
                pc = redir_addr;
                exp_q.delete();
                exp_q.push_back(mem_word(pc));
            end
            if (!instr_busy) begin
                check("sb_count", 32'(exp_q.size()), 1);
                if (exp_q.size() != 0) check("instr_data", instr_data, exp_q.pop_front());
                if (pc_q.size() == 0) done = 1'b1;
                else begin
                    pc = pc_q.pop_front();
                    exp_q.push_back(mem_word(pc));
                end
            end
            instr_addr = pc;
            if (!done && cycles >= budget) begin
                check("timeout", cycles, 0);
                exp_q.delete();
                pc_q.delete();
                done = 1'b1;
            end
        end
    endtask

    initial begin : main
        int unsigned cyc;
        int unsigned a0;

        // Reset values
        instr_addr = 32'h100;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", instr_busy, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_instr_data", instr_data, 0);

        // 1: cold miss at 0x100
        expect_fill(32'h100);
        pc_q = '{32'h100};
        rst_n = 1'b1;
        a0 = n_acks;
        run(50, 0, '0, cyc);
        check("t1_latency", cyc, 6);
        check("t1_acks", n_acks - a0, 4);

        // 2: sequential hits
        pc_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
        a0 = n_acks;
        run(20, 0, '0, cyc);
        check("t2_cycles", cyc, 4);
        check("t2_acks", n_acks - a0, 0);

        // 3: conflict on index 0
        expect_fill(32'h0);
        expect_fill(32'h400);
        expect_fill(32'h0);
        pc_q = '{32'h0, 32'h400, 32'h0};
        a0 = n_acks;
        run(100, 0, '0, cyc);
        check("t3_cycles", cyc, 18);
        check("t3_acks", n_acks - a0, 12);

        // 4: redirect to cached 0x80 during the 0x200 fill
        expect_fill(32'h80);
        pc_q = '{32'h80};
        run(50, 0, '0, cyc);
        expect_fill(32'h200);
        pc_q = '{32'h200};
        run(50, 3, 32'h80, cyc);
        check("t4_redir_cycles", cyc, 6);
        pc_q = '{32'h200, 32'h204};
        a0 = n_acks;
        run(20, 0, '0, cyc);
        check("t4_filled_cycles", cyc, 2);
        check("t4_filled_acks", n_acks - a0, 0);

        // 5: flush on the last ack
        flush_on_last = 1'b1;
        expect_fill(32'h300);
        pc_q = '{32'h300};
        run(50, 0, '0, cyc);
        flush_on_last = 1'b0;
        check("t5_fwd_cycles", cyc, 6);
        expect_fill(32'h300);
        pc_q = '{32'h300};
        a0 = n_acks;
        run(50, 0, '0, cyc);
        check("t5_refill_acks", n_acks - a0, 4);
        expect_fill(32'h80);
        pc_q = '{32'h80};
        a0 = n_acks;
        run(50, 0, '0, cyc);
        check("t5_flushed_acks", n_acks - a0, 4);

        // 6: slow memory, then reset mid-fill
        ack_delay = 3;
        expect_fill(32'h500);
        pc_q = '{32'h500};
        run(100, 0, '0, cyc);
        check("t6_slow_cycles", cyc, 18);
        instr_addr = 32'h600;
        @(posedge clk);
        #1;
        check("t6_miss_busy", instr_busy, 1);
        @(posedge clk);
        #1;
        check("t6_fill_req", mem_req, 1);
        check("t6_fill_addr", mem_addr, 32'h600);
        check("t6_fill_busy", instr_busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rst_req", mem_req, 0);
        check("t6_rst_busy", instr_busy, 1);
        check("t6_rst_addr", mem_addr, 0);
        ack_delay  = 0;
        instr_addr = 32'h100;
        expect_fill(32'h100);
        pc_q = '{32'h100};
        rst_n = 1'b1;
        a0 = n_acks;
        run(50, 0, '0, cyc);
        check("t6_after_rst_cycles", cyc, 6);
        check("t6_after_rst_acks", n_acks - a0, 4);
        check("fill_q_drained", 32'(fill_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
